spec_wakeup_matrix: RTL

- Next-generation scheduler wakeup block for the backend issue queue.
- Square dependency matrix: a row is a consumer entry and a column is the producer entry with the same index. A row requests issue when it is valid, not yet issued, and has no outstanding dependencies.
- Supports NUM_ISSUE grants per cycle with per-producer latency timers for speculative wakeup.
- Keeps a saved copy of each row's dependencies so a cancelled producer re-arms its dependents.

---
 rtl/spec_wakeup_matrix.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/spec_wakeup_matrix.sv
// Scheduler wakeup matrix: per-row dependency vectors cleared by producer
// completion, with speculative latency timers and cancel re-arm from saved deps.
module spec_wakeup_matrix #(
  parameter int unsigned NUM_ROWS  = 8,
  parameter int unsigned NUM_ISSUE = 2,
  parameter int unsigned MAX_LAT   = 8,
  parameter int unsigned IDXW      = $clog2(NUM_ROWS),
  parameter int unsigned LATW      = $clog2(MAX_LAT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_en,
  input  logic [IDXW-1:0]           alloc_row,
  input  logic [NUM_ROWS-1:0]       alloc_deps,
  input  logic [NUM_ISSUE-1:0]      issue_valid,
  input  logic [NUM_ISSUE*IDXW-1:0] issue_row,
  input  logic [NUM_ISSUE*LATW-1:0] issue_lat,
  input  logic                      cancel_en,
  input  logic [IDXW-1:0]           cancel_row,
  input  logic                      free_en,
  input  logic [IDXW-1:0]           free_row,
  input  logic                      flush,
  output logic [NUM_ROWS-1:0]       request_vector,
  output logic [NUM_ROWS-1:0]       pending_vector
);

  localparam logic [LATW-1:0] LAT_ONE = LATW'(1);
  localparam logic [LATW-1:0] LAT_MAX = LATW'(MAX_LAT);

  logic [NUM_ROWS-1:0] valid_q, valid_d;
  logic [NUM_ROWS-1:0] issued_q, issued_d;
  logic [NUM_ROWS-1:0] dep_q   [NUM_ROWS];
  logic [NUM_ROWS-1:0] dep_d   [NUM_ROWS];
  logic [NUM_ROWS-1:0] orig_q  [NUM_ROWS];
  logic [NUM_ROWS-1:0] orig_d  [NUM_ROWS];
  logic [LATW-1:0]     timer_q [NUM_ROWS];
  logic [LATW-1:0]     timer_d [NUM_ROWS];

  logic [NUM_ROWS-1:0] iss_hit;
  logic [LATW-1:0]     iss_lat [NUM_ROWS];
  logic [NUM_ROWS-1:0] cancel_hit, alloc_mask, free_mask;
  logic [NUM_ROWS-1:0] row_done, lat_one, timer_zero;
  logic [NUM_ROWS-1:0] clr_col, woken;

  always_comb begin : outputs
    request_vector = '0;
    pending_vector = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      request_vector[r] = valid_q[r] & ~issued_q[r] & ~(|dep_q[r]);
      pending_vector[r] = |timer_q[r];
    end
  end

  always_comb begin : issue_decode
    logic [IDXW-1:0] p;
    logic [LATW-1:0] lat;
    p       = '0;
    lat     = '0;
    iss_hit = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) iss_lat[r] = '0;
    for (int unsigned k = 0; k < NUM_ISSUE; k++) begin
      p   = issue_row[k*IDXW +: IDXW];
      lat = issue_lat[k*LATW +: LATW];
      if (lat == '0)          lat = LAT_ONE;
      else if (lat > LAT_MAX) lat = LAT_MAX;
      if (issue_valid[k] && request_vector[p]) begin
        iss_hit[p] = 1'b1;
        iss_lat[p] = lat;
      end
    end
  end

  always_comb begin : column_events
    cancel_hit = '0;
    alloc_mask = '0;
    free_mask  = '0;
    row_done   = '0;
    lat_one    = '0;
    timer_zero = '0;
    if (cancel_en && issued_q[cancel_row]) cancel_hit[cancel_row] = 1'b1;
    if (alloc_en) alloc_mask[alloc_row] = 1'b1;
    if (free_en)  free_mask[free_row]   = 1'b1;
    for (int unsigned c = 0; c < NUM_ROWS; c++) begin
      row_done[c]   = (timer_q[c] == LAT_ONE);
      lat_one[c]    = iss_hit[c] && (iss_lat[c] == LAT_ONE);
      timer_zero[c] = (timer_q[c] == '0);
    end
    // A cancelled producer neither clears its column nor counts as woken.
    clr_col = (row_done | lat_one) & ~cancel_hit;
    woken   = ((issued_q & timer_zero) | clr_col) & ~cancel_hit;
  end

  always_comb begin : next_state
    valid_d  = valid_q;
    issued_d = issued_q;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      dep_d[r]   = dep_q[r];
      orig_d[r]  = orig_q[r];
      timer_d[r] = timer_q[r];
    end
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (flush) begin
        valid_d[r]  = 1'b0;
        issued_d[r] = 1'b0;
        timer_d[r]  = '0;
        dep_d[r]    = '0;
        orig_d[r]   = '0;
      end else if (alloc_mask[r]) begin
        valid_d[r]  = 1'b1;
        issued_d[r] = 1'b0;
        timer_d[r]  = '0;
        dep_d[r]    = alloc_deps & ~woken & ~alloc_mask;
        orig_d[r]   = alloc_deps & ~woken & ~alloc_mask;
      end else if (free_mask[r]) begin
        valid_d[r]  = 1'b0;
        issued_d[r] = 1'b0;
        timer_d[r]  = '0;
        dep_d[r]    = '0;
        orig_d[r]   = '0;
      end else begin
        if (cancel_hit[r]) begin
          issued_d[r] = 1'b0;
          timer_d[r]  = '0;
        end else if (iss_hit[r]) begin
          issued_d[r] = 1'b1;
          timer_d[r]  = iss_lat[r] - LAT_ONE;
        end else if (timer_q[r] != '0) begin
          timer_d[r]  = timer_q[r] - LAT_ONE;
        end
        dep_d[r] = dep_q[r] & ~clr_col;
        if (valid_q[r] && !issued_q[r])
          dep_d[r] = (dep_d[r] & ~cancel_hit) | (orig_q[r] & cancel_hit);
        dep_d[r]  = dep_d[r] & ~free_mask;
        orig_d[r] = orig_q[r] & ~free_mask;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      issued_q <= '0;
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
        dep_q[r]   <= '0;
        orig_q[r]  <= '0;
        timer_q[r] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      issued_q <= issued_d;
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
        dep_q[r]   <= dep_d[r];
        orig_q[r]  <= orig_d[r];
        timer_q[r] <= timer_d[r];
      end
    end
  end

  always_ff @(posedge clk) begin : illegal_input_checks
    if (rst) begin
      for (int unsigned k = 0; k < NUM_ISSUE; k++)
        for (int unsigned j = k + 1; j < NUM_ISSUE; j++)
          assert (!(issue_valid[k] && issue_valid[j] &&
                    issue_row[k*IDXW +: IDXW] == issue_row[j*IDXW +: IDXW]));
      assert (!(alloc_en && valid_q[alloc_row] && !(free_en && free_row == alloc_row)));
    end
  end

endmodule
